iterative_subtractor: RTL and testbench



---
 rtl/iterative_subtractor.sv | 125 ++++++++++++
 tb/tb_iterative_subtractor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/iterative_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one CHUNK-bit slice per clock,
// with a registered borrow between slices and valid/ready on both sides.
module iterative_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("iterative_subtractor: WIDTH must be a multiple of CHUNK");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  logic [CHUNK:0]   slice;
  logic             last;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    vld_d    = vld_q;
    // Extra top bit of the slice result is the slice borrow-out
    slice = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
          - {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
          - {{CHUNK{1'b0}}, borrow_q};
    last  = (idx_q == LAST);
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = S_CALC;
        end
      end
      (state_q == S_CALC): begin
        diff_d[idx_q*CHUNK +: CHUNK] = slice[CHUNK-1:0];
        borrow_d = slice[CHUNK];
        idx_d    = idx_q + 1'b1;
        if (last) begin
          idx_d   = '0;
          bout_d  = slice[CHUNK];
          ovf_d   = (a_q[MSB] ^ b_q[MSB]) & (a_q[MSB] ^ diff_d[MSB]);
          vld_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      (state_q == S_DONE): begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      vld_q    <= vld_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign out_valid = vld_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_iterative_subtractor.sv
// Bench for iterative_subtractor: directed steps plus random regression
// on three instances (CHUNK = 8, 32, 4) against a full-width reference.
module tb_iterative_subtractor;

  typedef struct packed {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
  } res_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        in_valid  = '0;
  logic [2:0]        in_ready;
  logic [2:0][31:0]  a = '0;
  logic [2:0][31:0]  b = '0;
  logic [2:0]        bin = '0;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready = '0;
  logic [2:0][31:0]  diff;
  logic [2:0]        bout;
  logic [2:0]        ovf;

  int   vectors = 0;
  int   miscompares = 0;
  int   nn[3] = '{4, 1, 8};
  res_t sb[$];

  always #5 clk = ~clk;

  iterative_subtractor #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .bin(bin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .diff(diff[0]), .bout(bout[0]), .overflow(ovf[0])
  );

  iterative_subtractor #(.WIDTH(32), .CHUNK(32)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .bin(bin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .diff(diff[1]), .bout(bout[1]), .overflow(ovf[1])
  );

  iterative_subtractor #(.WIDTH(32), .CHUNK(4)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .bin(bin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .diff(diff[2]), .bout(bout[2]), .overflow(ovf[2])
  );

  function automatic res_t model(logic [31:0] av, logic [31:0] bv,
                                 logic bi);
    logic [32:0] r;
    res_t        e;
    r      = {1'b0, av} - {1'b0, bv} - {32'd0, bi};
    e.diff = r[31:0];
    e.bout = r[32];
    e.ovf  = (av[31] ^ bv[31]) & (av[31] ^ r[31]);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int k, logic [31:0] av, logic [31:0] bv,
                      logic bi);
    int t = 0;
    while (!in_ready[k] && t < 50) begin
      tick();
      t++;
    end
    chk("in_ready_before_send", 32'(in_ready[k]), 32'd1);
    a[k]        = av;
    b[k]        = bv;
    bin[k]      = bi;
    in_valid[k] = 1'b1;
    sb.push_back(model(av, bv, bi));
    tick();
    in_valid[k] = 1'b0;
    a[k]        = $urandom;
    b[k]        = $urandom;
  endtask

  task automatic recv(int k, int stall, bit poke);
    int   c = 0;
    res_t e;
    while (!out_valid[k] && c < 64) begin
      chk("in_ready_calc", 32'(in_ready[k]), 32'd0);
      tick();
      c++;
    end
    chk("latency", 32'(c), 32'(nn[k]));
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("diff", diff[k], e.diff);
    chk("bout", 32'(bout[k]), 32'(e.bout));
    chk("overflow", 32'(ovf[k]), 32'(e.ovf));
    for (int s = 0; s < stall; s++) begin
      if (poke && s == 1) begin
        in_valid[k] = 1'b1;
        a[k]        = 32'hDEAD_BEEF;
        b[k]        = 32'h0000_0001;
      end
      tick();
      in_valid[k] = 1'b0;
      chk("hold_valid", 32'(out_valid[k]), 32'd1);
      chk("hold_diff", diff[k], e.diff);
      chk("hold_flags", {30'd0, bout[k], ovf[k]}, {30'd0, e.bout, e.ovf});
      chk("hold_in_ready", 32'(in_ready[k]), 32'd0);
    end
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    chk("valid_drop", 32'(out_valid[k]), 32'd0);
    chk("in_ready_after", 32'(in_ready[k]), 32'd1);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_diff", diff[0], 32'd0);
    chk("rst_flags", {30'd0, bout[0], ovf[0]}, 32'd0);
    chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_post_rst", 32'(in_ready[0]), 32'd1);

    // Basic, underflow, cross-chunk borrow, signed overflow
    send(0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    recv(0, 0, 1'b0);
    send(0, 32'h0000_0000, 32'h0000_0001, 1'b0);
    recv(0, 0, 1'b0);
    send(0, 32'h1234_ABCD, 32'h1234_ABCD, 1'b1);
    recv(0, 1, 1'b0);
    send(0, 32'h0001_0000, 32'h0000_0000, 1'b1);
    recv(0, 0, 1'b0);
    send(0, 32'h8000_0000, 32'h0000_0001, 1'b0);
    recv(0, 0, 1'b0);

    // Backpressure with an ignored in_valid pulse, then a fresh op
    send(0, 32'h0000_1111, 32'h0000_0022, 1'b0);
    recv(0, 5, 1'b1);
    send(0, 32'd10, 32'd4, 1'b0);
    recv(0, 0, 1'b0);

    // Reset during the second CALC cycle aborts the op
    send(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid[0]), 32'd0);
    chk("abort_diff", diff[0], 32'd0);
    chk("abort_in_ready", 32'(in_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready_after", 32'(in_ready[0]), 32'd1);
    void'(sb.pop_back());
    repeat (6) begin
      tick();
      chk("no_stale_valid", 32'(out_valid[0]), 32'd0);
    end
    send(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    recv(0, 0, 1'b0);

    // Random regression on each chunk size
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        send(k, $urandom, $urandom, 1'($urandom_range(0, 1)));
        recv(k, $urandom_range(0, 3), 1'b0);
      end
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
